// File: rtl/rule_rr_scheduler_if.sv
// Scheduler <-> scheduled-module bundle for rule_rr_scheduler.
// master: the scheduler (drives grants and watchdog status).
// slave:  the scheduled module (drives readiness and global enable).
interface rule_rr_scheduler_if #(
  parameter int N = 10
) ();
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic          sched_en;
  logic [N-1:0]  rule_ready;
  logic [N-1:0]  rule_enable;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;
  logic          starve;
  logic [IW-1:0] starve_idx;

  modport master (
    input  sched_en, rule_ready,
    output rule_enable, grant_valid, grant_idx, starve, starve_idx
  );

  modport slave (
    output sched_en, rule_ready,
    input  rule_enable, grant_valid, grant_idx, starve, starve_idx
  );
endinterface

// File: rtl/rule_rr_scheduler.sv
// rule_rr_scheduler: grants at most one ready rule per cycle, rotating
// priority after each burst of up to BURST consecutive grants.
// Optional starvation watchdog: define RULE_SCHED_WATCHDOG_EN to build it;
// otherwise starve/starve_idx are tied low.
module rule_rr_scheduler #(
  parameter int N            = 10,
  parameter int BURST        = 1,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  rule_rr_scheduler_if.master  bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = $clog2(BURST + 1);

  // (base + off) mod N, with off < N
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) begin
      s = s - N;
    end else begin
      s = s;
    end
    return IW'(s);
  endfunction

  logic [IW-1:0] ptr_r, ptr_nx_s;
  logic [IW-1:0] owner_r, owner_nx_s;
  logic          owner_v_r, owner_v_nx_s;
  logic [BW-1:0] burst_cnt_r, burst_cnt_nx_s;

  logic          owner_hit_s;
  logic          scan_hit_s;
  logic [IW-1:0] scan_idx_s;
  logic          grant_v_s;
  logic [IW-1:0] grant_idx_s;
  logic [N-1:0]  enable_s;

  // Grant selection: burst continuation first, else rotating scan from ptr
  always_comb begin
    owner_hit_s = owner_v_r && bus.rule_ready[owner_r] && (burst_cnt_r < BW'(BURST));
    scan_hit_s  = 1'b0;
    scan_idx_s  = {IW{1'b0}};
    // walk from the farthest offset down so the nearest ready rule wins
    for (int i = N - 1; i >= 0; i--) begin
      scan_hit_s = scan_hit_s | bus.rule_ready[wrap_add(ptr_r, i)];
      scan_idx_s = bus.rule_ready[wrap_add(ptr_r, i)] ? wrap_add(ptr_r, i) : scan_idx_s;
    end
    if (RST || !bus.sched_en) begin
      grant_v_s   = 1'b0;
      grant_idx_s = {IW{1'b0}};
    end else if (owner_hit_s) begin
      grant_v_s   = 1'b1;
      grant_idx_s = owner_r;
    end else begin
      grant_v_s   = scan_hit_s;
      grant_idx_s = scan_idx_s;
    end
  end

  // One-hot-or-zero enable vector decoded from the grant
  always_comb begin
    enable_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      enable_s[i] = grant_v_s && (grant_idx_s == IW'(i));
    end
  end

  assign bus.rule_enable = enable_s;
  assign bus.grant_valid = grant_v_s;
  assign bus.grant_idx   = grant_idx_s;

  // Next pointer / owner / burst count from this cycle's grant outcome
  always_comb begin
    ptr_nx_s       = ptr_r;
    owner_nx_s     = owner_r;
    owner_v_nx_s   = owner_v_r;
    burst_cnt_nx_s = burst_cnt_r;
    if (grant_v_s) begin
      if (owner_v_r && (grant_idx_s == owner_r)) begin
        burst_cnt_nx_s = burst_cnt_r + 1'b1;
      end else begin
        owner_nx_s     = grant_idx_s;
        burst_cnt_nx_s = BW'(1'b1);
      end
      if (burst_cnt_nx_s == BW'(BURST)) begin
        ptr_nx_s     = wrap_add(grant_idx_s, 32'sd1);
        owner_v_nx_s = 1'b0;
      end else begin
        owner_v_nx_s = 1'b1;
      end
    end else begin
      // an idle or disabled cycle ends any burst and moves past its owner
      if (owner_v_r) begin
        ptr_nx_s = wrap_add(owner_r, 32'sd1);
      end else begin
        ptr_nx_s = ptr_r;
      end
      owner_v_nx_s   = 1'b0;
      burst_cnt_nx_s = {BW{1'b0}};
    end
  end

  // Scheduler state registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_r       <= {IW{1'b0}};
      owner_r     <= {IW{1'b0}};
      owner_v_r   <= 1'b0;
      burst_cnt_r <= {BW{1'b0}};
    end else begin
      ptr_r       <= ptr_nx_s;
      owner_r     <= owner_nx_s;
      owner_v_r   <= owner_v_nx_s;
      burst_cnt_r <= burst_cnt_nx_s;
    end
  end

`ifdef RULE_SCHED_WATCHDOG_EN
  localparam int WW = $clog2(STARVE_LIMIT + 1);

  logic [WW-1:0] wait_cnt_r    [N];
  logic [WW-1:0] wait_cnt_nx_s [N];
  logic          starve_r, starve_nx_s;
  logic [IW-1:0] starve_idx_r, starve_idx_nx_s;

  // Per-rule saturating wait counters and lowest starved index
  always_comb begin
    for (int i = 0; i < N; i++) begin
      wait_cnt_nx_s[i] = wait_cnt_r[i];
      if (!bus.rule_ready[i] || enable_s[i]) begin
        wait_cnt_nx_s[i] = {WW{1'b0}};
      end else if (bus.sched_en && (wait_cnt_r[i] != WW'(STARVE_LIMIT))) begin
        wait_cnt_nx_s[i] = wait_cnt_r[i] + 1'b1;
      end else begin
        wait_cnt_nx_s[i] = wait_cnt_r[i];
      end
    end
    starve_nx_s     = 1'b0;
    starve_idx_nx_s = {IW{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      starve_nx_s     = starve_nx_s | (wait_cnt_nx_s[i] == WW'(STARVE_LIMIT));
      starve_idx_nx_s = (wait_cnt_nx_s[i] == WW'(STARVE_LIMIT)) ? IW'(i) : starve_idx_nx_s;
    end
  end

  // Watchdog registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N; i++) begin
        wait_cnt_r[i] <= {WW{1'b0}};
      end
      starve_r     <= 1'b0;
      starve_idx_r <= {IW{1'b0}};
    end else begin
      for (int i = 0; i < N; i++) begin
        wait_cnt_r[i] <= wait_cnt_nx_s[i];
      end
      starve_r     <= starve_nx_s;
      starve_idx_r <= starve_idx_nx_s;
    end
  end

  assign bus.starve     = starve_r;
  assign bus.starve_idx = starve_idx_r;
`else
  assign bus.starve     = 1'b0;
  assign bus.starve_idx = {IW{1'b0}};
`endif

endmodule

// File: tb/tb_rule_rr_scheduler.sv
// Bench for rule_rr_scheduler: three N=10 instances (BURST 1, 2, 8; the
// BURST=8 one with STARVE_LIMIT=4) share one stimulus stream and are each
// compared every cycle against a queue-free arithmetic reference model.
module tb_rule_rr_scheduler;
  localparam int NI = 3;
`ifdef RULE_SCHED_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       en;
  logic [9:0] rdy;

  int checks;
  int failures;

  rule_rr_scheduler_if #(.N(10)) if_b1 ();
  rule_rr_scheduler_if #(.N(10)) if_b2 ();
  rule_rr_scheduler_if #(.N(10)) if_b8 ();

  assign if_b1.sched_en = en;  assign if_b1.rule_ready = rdy;
  assign if_b2.sched_en = en;  assign if_b2.rule_ready = rdy;
  assign if_b8.sched_en = en;  assign if_b8.rule_ready = rdy;

  rule_rr_scheduler #(.N(10), .BURST(1), .STARVE_LIMIT(64)) u_b1 (.CLK(clk), .RST(rst), .bus(if_b1.master));
  rule_rr_scheduler #(.N(10), .BURST(2), .STARVE_LIMIT(64)) u_b2 (.CLK(clk), .RST(rst), .bus(if_b2.master));
  rule_rr_scheduler #(.N(10), .BURST(8), .STARVE_LIMIT(4))  u_b8 (.CLK(clk), .RST(rst), .bus(if_b8.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state, one slot per instance
  int m_burst [NI] = '{1, 2, 8};
  int m_limit [NI] = '{64, 64, 4};
  int m_ptr   [NI];
  int m_owner [NI];
  int m_ov    [NI];
  int m_cnt   [NI];
  int m_wait  [NI][10];
  int m_starve[NI];
  int m_sidx  [NI];

  int burst_exp [8] = '{1, 1, 4, 4, 1, 1, 4, 4};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare one instance for the current cycle, then advance its model
  task automatic model_step(input int k, input logic [9:0] g_en, input logic g_v,
                            input logic [3:0] g_i, input logic st, input logic [3:0] si);
    int g;
    g = -1;
    if (!rst && en) begin
      if (m_ov[k] != 0 && rdy[m_owner[k]] && m_cnt[k] < m_burst[k]) begin
        g = m_owner[k];
      end else begin
        for (int j = 0; j < 10; j++) begin
          if (g < 0 && rdy[(m_ptr[k] + j) % 10]) g = (m_ptr[k] + j) % 10;
        end
      end
    end
    chk($sformatf("i%0d_enable", k), 32'(g_en), (g >= 0) ? (32'd1 << g) : 32'd0);
    chk($sformatf("i%0d_valid", k),  32'(g_v),  (g >= 0) ? 32'd1 : 32'd0);
    chk($sformatf("i%0d_idx", k),    32'(g_i),  (g >= 0) ? 32'(g) : 32'd0);
    chk($sformatf("i%0d_starve", k), 32'(st),   32'(m_starve[k]));
    chk($sformatf("i%0d_sidx", k),   32'(si),   32'(m_sidx[k]));

    if (rst) begin
      m_ptr[k] = 0; m_owner[k] = 0; m_ov[k] = 0; m_cnt[k] = 0;
      for (int i = 0; i < 10; i++) m_wait[k][i] = 0;
    end else begin
      for (int i = 0; i < 10; i++) begin
        if (!rdy[i] || i == g) m_wait[k][i] = 0;
        else if (en && m_wait[k][i] < m_limit[k]) m_wait[k][i]++;
      end
      if (g >= 0) begin
        if (m_ov[k] != 0 && g == m_owner[k]) m_cnt[k]++;
        else begin m_owner[k] = g; m_cnt[k] = 1; end
        m_ov[k] = 1;
        if (m_cnt[k] == m_burst[k]) begin m_ptr[k] = (g + 1) % 10; m_ov[k] = 0; end
      end else begin
        if (m_ov[k] != 0) m_ptr[k] = (m_owner[k] + 1) % 10;
        m_ov[k] = 0; m_cnt[k] = 0;
      end
    end
    m_starve[k] = 0; m_sidx[k] = 0;
    for (int i = 9; i >= 0; i--) begin
      if (WD && !rst && m_wait[k][i] == m_limit[k]) begin m_starve[k] = 1; m_sidx[k] = i; end
    end
  endtask

  // Drive one cycle of stimulus and check all instances mid-cycle
  task automatic step(input logic r, input logic e, input logic [9:0] rd);
    @(posedge clk);
    #1;
    rst = r; en = e; rdy = rd;
    @(negedge clk);
    model_step(0, if_b1.rule_enable, if_b1.grant_valid, if_b1.grant_idx, if_b1.starve, if_b1.starve_idx);
    model_step(1, if_b2.rule_enable, if_b2.grant_valid, if_b2.grant_idx, if_b2.starve, if_b2.starve_idx);
    model_step(2, if_b8.rule_enable, if_b8.grant_valid, if_b8.grant_idx, if_b8.starve, if_b8.starve_idx);
  endtask

  initial begin
    checks = 0; failures = 0;
    for (int k = 0; k < NI; k++) begin
      m_ptr[k] = 0; m_owner[k] = 0; m_ov[k] = 0; m_cnt[k] = 0; m_starve[k] = 0; m_sidx[k] = 0;
      for (int i = 0; i < 10; i++) m_wait[k][i] = 0;
    end
    rst = 1'b1; en = 1'b1; rdy = 10'h3FF;
    repeat (2) @(posedge clk);

    // reset holds grants off even with everything ready, then plain rotation
    step(1'b1, 1'b1, 10'h3FF);
    chk("rst_enable", 32'(if_b1.rule_enable), 32'd0);
    chk("rst_valid",  32'(if_b1.grant_valid), 32'd0);
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 1'b1, 10'h3FF);
      chk("rr_seq", 32'(if_b1.grant_idx), 32'(k % 10));
    end

    // bursts of two alternating between rules 1 and 4
    step(1'b1, 1'b1, 10'h000);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 10'b0000010010);
      chk("burst2", 32'(if_b2.grant_idx), 32'(burst_exp[k]));
    end

    // owner drops mid-burst: rule 7 takes over the same cycle
    step(1'b1, 1'b1, 10'h000);
    step(1'b0, 1'b1, 10'h088); chk("drop_a", 32'(if_b2.grant_idx), 32'd3);
    step(1'b0, 1'b1, 10'h080); chk("drop_b", 32'(if_b2.grant_idx), 32'd7);
    step(1'b0, 1'b1, 10'h088); chk("drop_c", 32'(if_b2.grant_idx), 32'd7);
    step(1'b0, 1'b1, 10'h088); chk("drop_d", 32'(if_b2.grant_idx), 32'd3);

    // sched_en low mid-burst on rule 5; scan resumes at 6
    step(1'b1, 1'b1, 10'h000);
    step(1'b0, 1'b1, 10'h120); chk("gate_first", 32'(if_b2.grant_idx), 32'd5);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 10'h120);
      chk("gate_off", 32'(if_b2.rule_enable), 32'd0);
    end
    step(1'b0, 1'b1, 10'h120); chk("gate_resume", 32'(if_b2.grant_idx), 32'd8);

    // only rule 9 ready: granted every cycle across pointer wrap
    step(1'b1, 1'b1, 10'h000);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b1, 10'h200);
      chk("wrap_idx",   32'(if_b1.grant_idx),   32'd9);
      chk("wrap_valid", 32'(if_b1.grant_valid), 32'd1);
    end

    // rule 0 holds a long burst while rule 2 starves
    step(1'b1, 1'b1, 10'h000);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, 10'h005);
      if (k < 8) chk("wd_owner", 32'(if_b8.grant_idx), 32'd0);
      if (k == 8) chk("wd_grant2", 32'(if_b8.grant_idx), 32'd2);
      if (k >= 4 && k <= 8) begin
        chk("wd_starve", 32'(if_b8.starve),     WD ? 32'd1 : 32'd0);
        chk("wd_sidx",   32'(if_b8.starve_idx), WD ? 32'd2 : 32'd0);
      end
      if (k == 9) chk("wd_clear", 32'(if_b8.starve), 32'd0);
    end

    // randomized traffic with occasional disable and reset
    for (int k = 0; k < 3000; k++) begin
      logic [9:0] r;
      r = 10'($urandom);
      if ($urandom_range(0, 2) == 0) r = r & 10'($urandom) & 10'($urandom);
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
